// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port, transmit enable and serial-side status of the UART drain engine.
// Latency: none; plain signal bundle.
// Backpressure: fifo_pop is the only flow-control signal; the engine pops only when it can start a frame.
interface fifo_uart_tx_if #(
  parameter int DWIDTH = 8
);
  logic              tx_en;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_data;
  logic              fifo_pop;
  logic              tx;
  logic              busy;
  logic              frame_done;

  // Controller/FIFO side: drives enable and the FIFO head, observes the line.
  modport master (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_pop,
    input  tx,
    input  busy,
    input  frame_done
  );

  // Drain engine side.
  modport slave (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_pop,
    output tx,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and sends each as a UART frame (start, data LSB first, stop).
// Latency: pop and capture on one edge, start bit from the next cycle; frame = (DWIDTH+2)*CLKDIV cycles.
// Backpressure: pops only when idle or in the last stop cycle, with tx_en high and the FIFO non-empty.
// Optional feature macro FIFO_UART_TX_PARITY_EN: adds an even-parity bit between the data bits and the
// stop bit, lengthening each frame by CLKDIV cycles.
module fifo_uart_tx #(
  parameter int DWIDTH = 8,
  parameter int CLKDIV = 434
) (
  input logic           clk_i,
  input logic           rst_i,
  fifo_uart_tx_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKDIV);
  localparam int BIT_W  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKDIV - 1);
  // One cycle before the end of a bit: lets frame_done come out of a register
  // and still land exactly on the final stop cycle.
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKDIV - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DWIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DWIDTH-1:0]   shift;
  logic [DWIDTH-1:0]   shift_nxt;
  logic                tx_q;
  logic                busy_q;
  logic                frame_done_q;
`ifdef FIFO_UART_TX_PARITY_EN
  // Even parity of the word, captured when the word is popped so the
  // shifting data register does not need to be re-examined later.
  logic                parity_q;
`endif

  logic baud_end;
  logic stop_last;
  logic start_ok;

  // Bit timing and start qualification; fifo_pop must be combinational so the
  // FIFO advances on the same edge that captures its head word.
  always_comb begin
    baud_end  = (baud_cnt == BAUD_LAST);
    stop_last = (state == STOP) && baud_end;
    start_ok  = bus.tx_en && !bus.fifo_empty && ((state == IDLE) || stop_last);
    shift_nxt = shift >> 1;
  end

  assign bus.fifo_pop   = start_ok;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

  // Frame sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (start_ok) begin
            shift    <= bus.fifo_data;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= ^bus.fifo_data;
`endif
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= shift_nxt;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              state   <= PARITY;
              tx_q    <= parity_q;
`else
              state   <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx_q    <= shift_nxt[0];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif

        STOP: begin
          if (baud_cnt == BAUD_PRE) begin
            frame_done_q <= 1'b1;
          end
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (start_ok) begin
              // Back-to-back: next start bit follows the stop bit with no gap.
              shift    <= bus.fifo_data;
              state    <= START;
              tx_q     <= 1'b0;
              busy_q   <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
              parity_q <= ^bus.fifo_data;
`endif
            end else begin
              state    <= IDLE;
              tx_q     <= 1'b1;
              busy_q   <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with CLKDIV=4 and a queue-backed FIFO model.
// Latency: expects the start bit the cycle after the pop and frame_done on the last stop cycle.
// Backpressure: drives tx_en/fifo_empty and checks pop placement against hand-computed frames.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif

  logic clk;
  logic rst;

  fifo_uart_tx_if #(.DWIDTH(DW)) bus ();

  fifo_uart_tx #(.DWIDTH(DW), .CLKDIV(DIV)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line levels in transmit order: bits[0] is the start bit.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;
    logic        more;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] fq [$];

  int n_chk  = 0;
  int n_pass = 0;

  logic s_tx, s_busy, s_fd, s_pop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  // Sample outputs mid-cycle, then advance past the edge and retire a pop.
  task automatic cyc();
    @(negedge clk);
    s_tx   = bus.tx;
    s_busy = bus.busy;
    s_fd   = bus.frame_done;
    s_pop  = bus.fifo_pop;
    @(posedge clk);
    #1;
    if (s_pop && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic idle_cycles(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk($sformatf("%s[%0d] {tx,busy,pop,done}", nm, i), {28'd0, s_tx, s_busy, s_pop, s_fd}, 32'b1000);
    end
  endtask

  task automatic pop_cycle(input string nm);
    cyc();
    chk({nm, " pop"}, {31'd0, s_pop}, 32'd1);
    chk({nm, " idle tx"}, {31'd0, s_tx}, 32'd1);
    chk({nm, " idle busy"}, {31'd0, s_busy}, 32'd0);
  endtask

  // Check a whole frame cycle by cycle; optionally drop tx_en after cycle drop_at.
  task automatic run_frame(input logic [10:0] bits, input logic more, input int drop_at, input string nm);
    int k;
    logic last;
    k = 0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < DIV; c++) begin
        cyc();
        k++;
        last = (b == NB - 1) && (c == DIV - 1);
        chk($sformatf("%s c%0d tx", nm, k), {31'd0, s_tx}, {31'd0, bits[b]});
        chk($sformatf("%s c%0d busy", nm, k), {31'd0, s_busy}, 32'd1);
        chk($sformatf("%s c%0d frame_done", nm, k), {31'd0, s_fd}, {31'd0, last});
        chk($sformatf("%s c%0d pop", nm, k), {31'd0, s_pop}, {31'd0, last & more});
        if (k == drop_at) bus.tx_en = 1'b0;
      end
    end
  endtask

  initial begin
`ifdef FIFO_UART_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'h54A, 1'b0};
    tbl[1] = '{8'h00, 11'h400, 1'b1};
    tbl[2] = '{8'hFF, 11'h5FE, 1'b1};
    tbl[3] = '{8'h3C, 11'h478, 1'b0};
    tbl[4] = '{8'h07, 11'h60E, 1'b0};
`else
    tbl[0] = '{8'hA5, 11'h34A, 1'b0};
    tbl[1] = '{8'h00, 11'h200, 1'b1};
    tbl[2] = '{8'hFF, 11'h3FE, 1'b1};
    tbl[3] = '{8'h3C, 11'h278, 1'b0};
    tbl[4] = '{8'h07, 11'h20E, 1'b0};
`endif

    rst        = 1'b1;
    bus.tx_en  = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    chk("reset {tx,busy,pop,done}",
        {28'd0, bus.tx, bus.busy, bus.fifo_pop, bus.frame_done}, 32'b1000);
    rst = 1'b0;

    // Enabled but empty: line must stay idle.
    bus.tx_en = 1'b1;
    idle_cycles(100, "empty");

    // Single word: one pop, one 4-cycle-per-bit frame, then idle.
    fq.push_back(tbl[0].data);
    drive_fifo();
    pop_cycle("single");
    run_frame(tbl[0].bits, tbl[0].more, -1, "single");
    idle_cycles(3, "after_single");

    // Three preloaded words: contiguous frames, pops on each stop_last.
    for (int i = 1; i <= 3; i++) fq.push_back(tbl[i].data);
    drive_fifo();
    pop_cycle("burst");
    for (int i = 1; i <= 3; i++) run_frame(tbl[i].bits, tbl[i].more, -1, $sformatf("burst%0d", i));
    idle_cycles(3, "after_burst");
    chk("burst fifo drained", fq.size(), 32'd0);

    // Odd-weight word (parity bit is 1 when parity is built in).
    fq.push_back(tbl[4].data);
    drive_fifo();
    pop_cycle("odd");
    run_frame(tbl[4].bits, tbl[4].more, -1, "odd");
    idle_cycles(2, "after_odd");

    // tx_en dropped mid-frame with a second word queued.
    fq.push_back(tbl[0].data);
    fq.push_back(tbl[4].data);
    drive_fifo();
    pop_cycle("gate");
    run_frame(tbl[0].bits, 1'b0, 10, "gate1");
    idle_cycles(20, "gated");
    chk("gated word still queued", fq.size(), 32'd1);
    bus.tx_en = 1'b1;
    pop_cycle("gate_resume");
    run_frame(tbl[4].bits, 1'b0, -1, "gate2");
    idle_cycles(2, "after_gate");

    // Reset during data bit 3 (cycles 17..20 of the frame).
    fq.push_back(tbl[0].data);
    drive_fifo();
    pop_cycle("rst");
    for (int i = 0; i < 18; i++) cyc();
    chk("rst pre tx (bit3)", {31'd0, bus.tx}, 32'd0);
    chk("rst pre busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst async tx", {31'd0, bus.tx}, 32'd1);
    chk("rst async busy", {31'd0, bus.busy}, 32'd0);
    chk("rst async pop", {31'd0, bus.fifo_pop}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(30, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side drain engine for the team's synchronous FIFO. It pops words from the FIFO's read port and serializes each one as an asynchronous UART frame on a single TX line. It sits between a FIFO filled by the CPU/bus side and the board's serial pin. It generates its own baud timing from clk_i with a fixed divisor.

Parameters:
DWIDTH, 8, data bits per frame; must match the FIFO DWIDTH.
CLKDIV, 434, clk_i cycles per bit period; minimum 2; baud counter width is $clog2(CLKDIV).

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset
tx_en  input  1  1 = frames may start; 0 = finish the current frame, then hold idle
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DWIDTH  FIFO head word; combinational, valid whenever fifo_empty=0
fifo_pop  output  1  one-cycle pop strobe to the FIFO
tx  output  1  serial line; idles high
busy  output  1  1 while a frame is in progress (any state other than IDLE)
frame_done  output  1  one-cycle pulse in the last cycle of each stop bit

Behaviour:
- Reset: rst_i asynchronous, active-high; clock clk_i.
- Reset values: tx=1, fifo_pop=0, busy=0, frame_done=0, state=IDLE, all counters 0, shift register 0.
- Reset mid-frame: tx returns to 1 immediately. The partial frame is abandoned and is not retried. The FIFO word was already popped.
- fifo_pop is combinational: start_ok = tx_en && !fifo_empty && (state==IDLE || stop_last).
  - stop_last = state==STOP && baud_cnt==CLKDIV-1.
  - fifo_pop = start_ok.
  - In the same edge, fifo_data is latched into the shift register, baud_cnt is cleared, and state goes to START.
  - fifo_pop never asserts while fifo_empty=1. At most one pop per frame.
- States:
  - IDLE: tx=1. Leaves IDLE on start_ok.
  - START: tx=0 for CLKDIV cycles, then DATA with bit_cnt=0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKDIV cycles. At the end of a bit, shift right and increment bit_cnt. After bit DWIDTH-1, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: tx=1 for CLKDIV cycles. On stop_last, frame_done=1. Go to START if start_ok, otherwise IDLE.
- Back-to-back frames have no idle gap. A frame is exactly (DWIDTH+2)*CLKDIV cycles, or +CLKDIV with parity.
- Counters: baud_cnt counts 0..CLKDIV-1 and wraps to 0 at each bit boundary. bit_cnt counts 0..DWIDTH-1.
- tx is driven from a register: the new state's level appears on the first cycle after the transition edge, with no glitches.
- tx_en falling mid-frame: the frame completes normally and no further pop occurs. tx_en rising while the FIFO is non-empty and idle: pop in that same cycle.
- A FIFO that goes empty mid-frame has no effect until stop_last.

Optional Feature:
Macro FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA. tx = XOR of all DWIDTH data bits (even parity) for CLKDIV cycles, then STOP. The parity bit is computed when the word is latched.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset, then hold with fifo_empty=1 and tx_en=1 for 100 cycles -> tx=1, fifo_pop=0, busy=0 throughout.
- CLKDIV=4, fifo_data=8'hA5, fifo_empty drops for one cycle:
  - fifo_pop pulses once.
  - tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - frame_done pulses at cycle 40.
  - busy is high for 40 cycles.
- CLKDIV=4, FIFO preloaded with 8'h00, 8'hFF, 8'h3C -> three contiguous 40-cycle frames with no idle cycle between stop and next start. Exactly 3 pops; each pop is coincident with stop_last of the previous frame.
- tx_en dropped at cycle 10 of frame 1 of 2 queued words -> frame 1 completes intact. tx stays 1 and no second pop until tx_en returns, then frame 2 starts in that cycle.
- rst_i pulsed during DATA bit 3 -> tx=1 asynchronously, busy=0. After release with the FIFO empty, the line stays idle with no pop.
- With FIFO_UART_TX_PARITY_EN defined, CLKDIV=4, data 8'h07 -> parity bit=1 between bit 7 and stop. Frame is 44 cycles.
